mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port if_req  input  1  instruction-fetch word read request, held until if_rdy.
REQ-004 SHALL have port if_addr  input  32  fetch byte address.
REQ-005 SHALL have port if_flush  input  1  abort in-flight fetch (branch redirect).
REQ-006 SHALL have port if_rdy  output  1  one-cycle pulse: if_data valid.
REQ-007 SHALL have port if_data  output  32  fetched word, little-endian.
REQ-008 SHALL have port mm_req  input  1  load/store request, held until mm_rdy.
REQ-009 SHALL have port mm_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port mm_width  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 SHALL have port mm_addr  input  32  load/store byte address.
REQ-012 SHALL have port mm_wdata  input  32  store data; byte k = mm_wdata[8k+7:8k].
REQ-013 SHALL have port mm_rdy  output  1  one-cycle pulse: access complete, mm_rdata valid for loads.
REQ-014 SHALL have port mm_rdata  output  32  load bytes, zero-extended above width; extension is done downstream.
REQ-015 SHALL have port ram_a  output  32  byte address to single-port RAM.
REQ-016 SHALL have port ram_wr  output  1  1 = write ram_dout at ram_a this cycle.
REQ-017 SHALL have port ram_dout  output  8  write byte to RAM.
REQ-018 SHALL have port ram_din  input  8  read byte, valid one cycle after its address is presented.

Function
REQ-019 SHALL implement FSM IDLE, IF_RD, MM_RD, MM_WR; N = bytes (1/2/4; fetch always 4).
REQ-020 In IDLE, mm_req SHALL win over if_req when both are high; no preemption once a transaction starts.
REQ-021 Acceptance cycle = cycle 0, in IDLE with req high; base address, width, we and wdata SHALL be latched at that edge.
REQ-022 In cycles 1..N, ram_a SHALL equal base+k, k = cycle-1; base+k SHALL wrap modulo 2^32.
REQ-023 Reads: byte presented in cycle j SHALL be captured from ram_din in cycle j+1 into lane j-1.
REQ-024 Reads: rdy SHALL pulse in cycle N+1; data SHALL be valid that cycle and SHALL hold until the next acceptance.
REQ-025 Writes: ram_wr=1, ram_dout = latched wdata byte k in cycles 1..N; mm_rdy SHALL pulse in cycle N+1 with ram_wr=0.
REQ-026 The FSM SHALL return to IDLE after cycle N+1; next acceptance no earlier than cycle N+2; requester drops or renews req in that cycle.
REQ-027 Outside write cycles ram_wr SHALL be 0; in IDLE, ram_a and ram_dout SHALL be 0.
REQ-028 if_flush high in IF_RD SHALL force IDLE at the next edge with no if_rdy.
REQ-029 if_flush in IDLE SHALL block if_req acceptance in that cycle.
REQ-030 if_flush SHALL have no effect on MM_RD or MM_WR.
REQ-031 Each rdy SHALL be a single-cycle pulse, never asserted in IDLE; if_rdy and mm_rdy SHALL never be high together.

Reset
REQ-032 rst low SHALL immediately force IDLE, counter 0, latches 0, all outputs 0, including mid-transaction; no rdy after release.
REQ-033 The first acceptance SHALL be possible in the first cycle with rst high.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, mm_width codes and the RAM data width constant (8).
REQ-035 A byte-lane assembler sub-module, mem_lane_asm (capture ram_din into the lane selected by a 2-bit index, clear on accept), is the single natural sub-module; the rest stays flat.

Verification
REQ-036 Fetch: if_req, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> ram_a 0x100..0x103 in cycles 1-4; if_rdy cycle 5; if_data=0x00000513.
REQ-037 Collision: if_req and mm_req (load word, 0x2000) same cycle -> MM_RD first, mm_rdy cycle 5; fetch accepted cycle 6, if_rdy cycle 11.
REQ-038 Store half: mm_addr=0x3001, mm_wdata=0xAABBCCDD -> ram_wr cycles 1-2, bytes DD@0x3001, CC@0x3002; mm_rdy cycle 3.
REQ-039 Load byte at 0xFFFFFFFF, RAM=0x80 -> mm_rdata=0x00000080, mm_rdy cycle 2; half at 0xFFFFFFFF reads 0xFFFFFFFF then 0x00000000 (wrap).
REQ-040 Flush: fetch accepted, if_flush in cycle 2 -> IDLE cycle 3, no if_rdy; new fetch accepted cycle 3.
REQ-041 Reset mid-store (cycle 2 of word store) -> ram_wr=0 at once; after release no mm_rdy; IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// access-width codes and the RAM data width.
package mem_ctrl_pkg;

  localparam int RAM_DW = 8;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    MM_RD = 2'd2,
    MM_WR = 2'd3
  } state_t;

  // Code 2'b11 falls into the default and behaves as a word access.
  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_asm.sv
// Byte-lane assembler: captures a RAM read byte into the selected lane and
// forwards it in the same cycle so the completed word is visible on capture.
module mem_lane_asm
  import mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [1:0]          idx,
  input  logic [RAM_DW-1:0]   din,
  output logic [4*RAM_DW-1:0] word
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic              hit;
      logic [RAM_DW-1:0] lane_reg;

      assign hit = en && (idx == 2'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (clr) begin
          lane_reg <= '0;
        end else if (hit) begin
          lane_reg <= din;
        end
      end

      assign word[gi*RAM_DW +: RAM_DW] = hit ? din : lane_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store requests onto a byte-wide
// single-port RAM, walking the access one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_rdy,
  output logic [31:0]       if_data,
  input  logic              mm_req,
  input  logic              mm_we,
  input  logic [1:0]        mm_width,
  input  logic [31:0]       mm_addr,
  input  logic [31:0]       mm_wdata,
  output logic              mm_rdy,
  output logic [31:0]       mm_rdata,
  output logic [31:0]       ram_a,
  output logic              ram_wr,
  output logic [RAM_DW-1:0] ram_dout,
  input  logic [RAM_DW-1:0] ram_din
);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] base_reg;
  logic [1:0]  width_reg;
  logic [31:0] wdata_reg;

  logic        accept;
  logic        cap_en;
  logic [1:0]  cap_idx;
  logic [2:0]  n_bytes;
  logic        done;
  logic [31:0] word;

  // Fetches latch WIDTH_WORD, so one lookup covers both requesters.
  assign n_bytes = width_bytes(width_reg);
  assign done    = (cnt_reg == n_bytes);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      base_reg  <= '0;
      width_reg <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        base_reg  <= mm_req ? mm_addr  : if_addr;
        width_reg <= mm_req ? mm_width : WIDTH_WORD;
        wdata_reg <= mm_req ? mm_wdata : '0;
      end
    end
  end

  // cnt_reg runs 0..N through cycles 1..N+1 of a transaction.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    ram_a      = '0;
    ram_wr     = 1'b0;
    ram_dout   = '0;
    if_rdy     = 1'b0;
    mm_rdy     = 1'b0;
    cap_en     = 1'b0;
    cap_idx    = cnt_reg[1:0] - 2'd1;

    case (state_reg)
      IDLE: begin
        if (mm_req) begin
          accept     = 1'b1;
          state_next = mm_we ? MM_WR : MM_RD;
          cnt_next   = '0;
        end else if (if_req && !if_flush) begin
          accept     = 1'b1;
          state_next = IF_RD;
          cnt_next   = '0;
        end
      end

      default: begin
        if (!done) begin
          ram_a = base_reg + {29'd0, cnt_reg};
        end

        if (state_reg == MM_WR) begin
          ram_wr = !done;
          if (!done) begin
            ram_dout = wdata_reg[{cnt_reg[1:0], 3'b000} +: RAM_DW];
          end
        end else begin
          cap_en = (cnt_reg != 3'd0);
        end

        if (done) begin
          state_next = IDLE;
          if_rdy     = (state_reg == IF_RD);
          mm_rdy     = (state_reg != IF_RD);
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end

        // A redirect discards the fetch, including one that would finish now.
        if (state_reg == IF_RD && if_flush) begin
          state_next = IDLE;
          if_rdy     = 1'b0;
          cap_en     = 1'b0;
        end
      end
    endcase
  end

  mem_lane_asm u_lane_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (cap_en),
    .idx  (cap_idx),
    .din  (ram_din),
    .word (word)
  );

  assign if_data  = word;
  assign mm_rdata = word;

endmodule
